// File: rtl/tx_fifo.sv
// tx_fifo: transmit-side byte FIFO for the USB endpoint, first-word-fall-through read port.
// Ports:
//    clk       system clock, rising edge
//    n_rst     asynchronous active-low reset
//    clear     synchronous flush; overrides push/pop in the same cycle
//    w_enable  push w_data this cycle
//    w_data    byte to push
//    r_enable  pop the head entry this cycle
//    r_data    head byte, 8'h00 while empty
//    full      registered, count == DEPTH
//    empty     registered, count == 0
//    count     occupancy 0..DEPTH
//    error     sticky misuse flag: push while full or pop while empty
module tx_fifo #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              clear,
   input  logic              w_enable,
   input  logic [7:0]        w_data,
   input  logic              r_enable,
   output logic [7:0]        r_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              error
);
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   cnt_nxt;
   logic              wr_ok, rd_ok, err_set;
   // a pop while full frees a slot in the same cycle, so the push still fits
   assign wr_ok = w_enable && (!full || r_enable);
   assign rd_ok = r_enable && !empty;
   // a pop on empty paired with a push is treated as a plain push, not misuse
   assign err_set = (w_enable && full && !r_enable) || (r_enable && empty && !w_enable);
   assign cnt_nxt = count + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
   assign r_data = empty ? 8'h00 : mem[rd_ptr];
   always_ff @(posedge clk)
      if (wr_ok && !clear) mem[wr_ptr] <= w_data;
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
         error  <= 1'b0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
         error  <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
         count <= cnt_nxt;
         empty <= cnt_nxt == '0;
         full  <= cnt_nxt == (ADDR_W+1)'(DEPTH);
         error <= error | err_set;
      end
endmodule

// File: tb/tb_tx_fifo.sv
// tb_tx_fifo: table vectors plus a scoreboard-checked bench for tx_fifo.
module tb_tx_fifo;
   localparam int DEPTH = 64;
   logic       clk = 1'b0;
   logic       n_rst, clear, w_enable, r_enable;
   logic [7:0] w_data, r_data;
   logic       full, empty, error;
   logic [6:0] count;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb [$];
   int         mcount = 0;
   logic       merr = 1'b0;
   typedef struct {
      logic       w;
      logic [7:0] d;
      logic       r;
      logic       c;
      int         e_count;
      logic       e_empty;
      logic       e_full;
      logic       e_err;
      logic [7:0] e_rdata;
   } vec_t;
   vec_t vt [7];
   tx_fifo #(.DEPTH(DEPTH), .ADDR_W(6)) dut (
      .clk(clk), .n_rst(n_rst), .clear(clear), .w_enable(w_enable), .w_data(w_data),
      .r_enable(r_enable), .r_data(r_data), .full(full), .empty(empty), .count(count), .error(error)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic chk_state();
      chk("count", int'(count), mcount);
      chk("empty", int'(empty), int'(mcount == 0));
      chk("full", int'(full), int'(mcount == DEPTH));
      chk("error", int'(error), int'(merr));
      chk("r_data", int'(r_data), sb.size() == 0 ? 0 : int'(sb[0]));
   endtask
   task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
      logic wa, ra;
      @(negedge clk);
      w_enable = w; w_data = d; r_enable = r; clear = c;
      if (c) begin
         sb.delete(); mcount = 0; merr = 1'b0;
      end else begin
         ra = r && mcount != 0;
         wa = w && (mcount != DEPTH || r);
         if (ra) chk("pop_data", int'(r_data), int'(sb.pop_front()));
         if (wa) sb.push_back(d);
         if ((w && mcount == DEPTH && !r) || (r && mcount == 0 && !w)) merr = 1'b1;
         mcount = mcount + int'(wa) - int'(ra);
      end
      @(posedge clk); #1;
      chk_state();
   endtask
   initial begin
      n_rst = 1'b0; clear = 1'b0; w_enable = 1'b0; r_enable = 1'b0; w_data = 8'h00;
      vt[0] = '{0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00};
      vt[1] = '{1, 8'hA5, 0, 0, 1, 0, 0, 0, 8'hA5};
      vt[2] = '{1, 8'h3C, 0, 0, 2, 0, 0, 0, 8'hA5};
      vt[3] = '{0, 8'h00, 1, 0, 1, 0, 0, 0, 8'h3C};
      vt[4] = '{0, 8'h00, 1, 0, 0, 1, 0, 0, 8'h00};
      vt[5] = '{1, 8'h11, 1, 0, 1, 0, 0, 0, 8'h11};
      vt[6] = '{0, 8'h00, 1, 0, 0, 1, 0, 0, 8'h00};
      #12;
      chk("rst_count", int'(count), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_error", int'(error), 0);
      chk("rst_rdata", int'(r_data), 0);
      @(negedge clk); n_rst = 1'b1;
      for (int i = 0; i < 7; i++) begin
         cyc(vt[i].w, vt[i].d, vt[i].r, vt[i].c);
         chk($sformatf("vec%0d_count", i), int'(count), vt[i].e_count);
         chk($sformatf("vec%0d_empty", i), int'(empty), int'(vt[i].e_empty));
         chk($sformatf("vec%0d_full", i), int'(full), int'(vt[i].e_full));
         chk($sformatf("vec%0d_error", i), int'(error), int'(vt[i].e_err));
         chk($sformatf("vec%0d_rdata", i), int'(r_data), int'(vt[i].e_rdata));
      end
      for (int i = 0; i < 64; i++) cyc(1, 8'(i), 0, 0);
      chk("fill_full", int'(full), 1);
      chk("fill_count", int'(count), 64);
      cyc(1, 8'hFF, 0, 0);
      chk("ovf_error", int'(error), 1);
      chk("ovf_count", int'(count), 64);
      for (int i = 0; i < 64; i++) begin
         if (i == 63) chk("drain_last", int'(r_data), 8'h3F);
         cyc(0, 8'h00, 1, 0);
      end
      chk("drain_empty", int'(empty), 1);
      cyc(0, 8'h00, 0, 1);
      for (int i = 0; i < 64; i++) cyc(1, 8'(i), 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 8'(8'h80 + i), 1, 0);
      chk("both_full", int'(full), 1);
      chk("both_count", int'(count), 64);
      chk("both_head", int'(r_data), 8'h03);
      for (int i = 0; i < 64; i++) cyc(0, 8'h00, 1, 0);
      for (int i = 0; i < 40; i++) cyc(1, 8'(8'hC0 + i), 0, 0);
      for (int i = 0; i < 40; i++) cyc(0, 8'h00, 1, 0);
      for (int i = 0; i < 40; i++) cyc(1, 8'(8'h10 + i), 0, 0);
      chk("wrap_head", int'(r_data), 8'h10);
      for (int i = 0; i < 40; i++) cyc(0, 8'h00, 1, 0);
      chk("wrap_count", int'(count), 0);
      for (int i = 0; i < 5; i++) cyc(1, 8'(8'h50 + i), 0, 0);
      cyc(1, 8'hEE, 1, 1);
      chk("clr_count", int'(count), 0);
      chk("clr_empty", int'(empty), 1);
      chk("clr_error", int'(error), 0);
      cyc(0, 8'h00, 1, 0);
      chk("uflow_error", int'(error), 1);
      for (int i = 0; i < 3; i++) cyc(1, 8'(8'h70 + i), 0, 0);
      w_enable = 1'b1; w_data = 8'h99;
      #2 n_rst = 1'b0;
      #1;
      chk("arst_count", int'(count), 0);
      chk("arst_empty", int'(empty), 1);
      chk("arst_full", int'(full), 0);
      chk("arst_error", int'(error), 0);
      chk("arst_rdata", int'(r_data), 0);
      sb.delete(); mcount = 0; merr = 1'b0;
      @(negedge clk); w_enable = 1'b0; n_rst = 1'b1;
      cyc(1, 8'h42, 0, 0);
      cyc(0, 8'h00, 1, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
